// File: rtl/knight_ctrl.sv
// knight_ctrl: command-driven step sequencer for a Knight Rider style LED scanner.
// Optional feature: define KNIGHT_CTRL_SWEEP_LIMIT_EN to stop RUN after N sweeps.
module knight_ctrl #(
    parameter int               WIDTH       = 8,
    parameter int               DIV_W       = 24,
    parameter logic [DIV_W-1:0] DIV_DEFAULT = 24'd4999999,
    parameter int               CYCLE_LEN   = 2*WIDTH+2
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [DIV_W-1:0] cmd_data,
    output logic             step,
    output logic             running,
    output logic             sweep_done
);

    localparam int               POS_W    = (CYCLE_LEN > 1) ? $clog2(CYCLE_LEN) : 1;
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(CYCLE_LEN - 1);

    localparam logic [1:0] OP_STOP = 2'b00;
    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_STEP = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] div_cnt;
    logic [POS_W-1:0] pos;

    logic accept;
    logic cmd_stop;
    logic cmd_run;
    logic cmd_step;
    logic cmd_load;
    logic term;
    logic limit_hit;
    logic step_next;

    assign accept   = cmd_valid && cmd_ready;
    assign cmd_stop = accept && (cmd_op == OP_STOP);
    assign cmd_run  = accept && (cmd_op == OP_RUN);
    assign cmd_step = accept && (cmd_op == OP_STEP);
    assign cmd_load = accept && (cmd_op == OP_LOAD);
    assign term     = (div_cnt == div_reg);

`ifdef KNIGHT_CTRL_SWEEP_LIMIT_EN
    logic [7:0] limit;
    logic [7:0] sweep_cnt;

    // The sweep_done being counted right now is the one that reaches the limit.
    assign limit_hit = (state == S_RUN) && sweep_done && (limit != 8'd0) &&
                       (sweep_cnt + 8'd1 == limit);

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            limit     <= '0;
            sweep_cnt <= '0;
        end else if ((state == S_IDLE) && cmd_run) begin
            limit     <= cmd_data[7:0];
            sweep_cnt <= '0;
        end else if (sweep_done) begin
            sweep_cnt <= sweep_cnt + 8'd1;
        end
    end
`else
    assign limit_hit = 1'b0;
`endif

    // An accepted STOP/LOAD_DIV or a reached sweep limit suppresses a terminal-count step.
    always_comb begin
        step_next = 1'b0;
        case (state)
            S_IDLE:  step_next = cmd_step;
            S_RUN:   step_next = term && !cmd_stop && !cmd_load && !limit_hit;
            default: step_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            cmd_ready  <= 1'b0;
            step       <= 1'b0;
            running    <= 1'b0;
            sweep_done <= 1'b0;
            div_reg    <= DIV_DEFAULT;
            div_cnt    <= '0;
            pos        <= '0;
        end else begin
            cmd_ready  <= 1'b1;
            step       <= step_next;
            sweep_done <= step_next && (pos == POS_LAST);
            if (step_next) begin
                pos <= (pos == POS_LAST) ? '0 : pos + POS_W'(1);
            end

            case (state)
                S_IDLE: begin
                    if (cmd_load) begin
                        div_reg <= cmd_data;
                        div_cnt <= '0;
                    end else if (cmd_stop) begin
                        div_cnt <= '0;
                    end else if (cmd_run) begin
                        state   <= S_RUN;
                        running <= 1'b1;
                        div_cnt <= '0;
                    end else if (cmd_step) begin
                        state     <= S_STEP;
                        cmd_ready <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (cmd_load) begin
                        div_reg <= cmd_data;
                    end
                    if (cmd_stop || cmd_load || term) begin
                        div_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                    if (cmd_stop || limit_hit) begin
                        state   <= S_IDLE;
                        running <= 1'b0;
                        div_cnt <= '0;
                    end
                end
                S_STEP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state   <= S_IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_knight_ctrl.sv
// Directed-vector bench for knight_ctrl (WIDTH=8, so one sweep is 18 steps).
module tb_knight_ctrl;

    localparam int WIDTH = 8;
    localparam int DIV_W = 24;

    localparam logic [1:0] OP_STOP = 2'b00;
    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_STEP = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    logic             clk_in    = 1'b0;
    logic             reset_n   = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op    = 2'b00;
    logic [DIV_W-1:0] cmd_data  = '0;
    logic             step;
    logic             running;
    logic             sweep_done;

    int nvec = 0;
    int nerr = 0;

    always #5 clk_in = ~clk_in;

    knight_ctrl #(
        .WIDTH(WIDTH),
        .DIV_W(DIV_W)
    ) dut (
        .clk_in    (clk_in),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .step      (step),
        .running   (running),
        .sweep_done(sweep_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [DIV_W-1:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = OP_STOP;
        cmd_data  = '0;
    endtask

    initial begin
        int steps;
        int sds;

        // Reset held across edges, then released
        repeat (2) @(posedge clk_in);
        #1;
        chk("rst_ready", cmd_ready, 0);
        chk("rst_step", step, 0);
        chk("rst_running", running, 0);
        chk("rst_sweep", sweep_done, 0);
        reset_n = 1'b1;
        #2;
        chk("rel_ready_pre_edge", cmd_ready, 0);
        tick();
        chk("rel_ready", cmd_ready, 1);

        // LOAD_DIV 3 then RUN: step on every 4th edge
        send(OP_LOAD, 24'd3);
        chk("load_running", running, 0);
        send(OP_RUN, 24'd0);
        chk("run_running", running, 1);
        chk("run_step0", step, 0);
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("div3_step", step, (i % 4 == 0));
        end

        // STEP during RUN leaves the cadence alone
        send(OP_STEP, 24'd0);
        chk("runstep_step", step, 0);
        chk("runstep_ready", cmd_ready, 1);
        chk("runstep_running", running, 1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("runstep_cadence", step, (i == 3));
        end

        // STOP on the terminal-count edge: no step
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("pre_stop_step", step, 0);
        end
        send(OP_STOP, 24'd0);
        chk("stop_tc_step", step, 0);
        chk("stop_running", running, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("idle_step", step, 0);
        end

        // div 0: continuous steps; 4 steps already taken, so sweeps at k=14 and k=32
        send(OP_LOAD, 24'd0);
        send(OP_RUN, 24'd0);
        chk("div0_first_step", step, 0);
        chk("div0_running", running, 1);
        for (int k = 1; k <= 34; k++) begin
            tick();
            chk("div0_step", step, 1);
            chk("div0_sweep", sweep_done, (k == 14 || k == 32));
        end
        send(OP_STOP, 24'd0);
        chk("div0_stop_step", step, 0);
        chk("div0_stop_running", running, 0);
        tick();
        chk("div0_after_stop", step, 0);

        // Single STEP from IDLE
        send(OP_STEP, 24'd0);
        chk("step_pulse", step, 1);
        chk("step_ready", cmd_ready, 0);
        chk("step_running", running, 0);
        chk("step_sweep", sweep_done, 0);
        tick();
        chk("step_end", step, 0);
        chk("step_end_ready", cmd_ready, 1);

        // Reset mid-RUN between steps
        send(OP_LOAD, 24'd3);
        send(OP_RUN, 24'd0);
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        chk("midrst_step", step, 0);
        chk("midrst_running", running, 0);
        chk("midrst_ready", cmd_ready, 0);
        chk("midrst_sweep", sweep_done, 0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("postrst_step", step, 0);
            chk("postrst_running", running, 0);
        end

        // div 1, RUN with limit field 2: step every 2 cycles from a fresh position
        send(OP_LOAD, 24'd1);
        send(OP_RUN, 24'd2);
        steps = 0;
        sds   = 0;
        for (int i = 1; i <= 80; i++) begin
            tick();
            steps += int'(step);
            sds   += int'(sweep_done);
        end
`ifdef KNIGHT_CTRL_SWEEP_LIMIT_EN
        chk("limit_steps", steps, 36);
        chk("limit_sweeps", sds, 2);
        chk("limit_running", running, 0);
`else
        chk("nolimit_steps", steps, 40);
        chk("nolimit_sweeps", sds, 2);
        chk("nolimit_running", running, 1);
        send(OP_STOP, 24'd0);
        chk("nolimit_stop", running, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
